opb_register_bank_simulink2ppc: RTL
===================================

Name: opb_register_bank_simulink2ppc

Overview:
Parametrised OPB slave exposing C_NUM_REGS user-side status words to the PPC as a block of read-only registers.
Generalises the single-word simulink2ppc register in three ways: multiple channels, configurable user width, and an optional atomic snapshot mode.
Snapshots are triggered by software or by a hardware strobe, and a wrapping snapshot counter is provided.
Single clock domain: user data must already be synchronous to OPB_Clk.

Parameters:
C_BASEADDR, 32'h01080100, first byte address of the block
C_HIGHADDR, 32'h010801FF, last byte address; must cover 0x10+4*C_NUM_REGS bytes
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (fixed 32)
C_NUM_REGS, 4, number of user channels, 1..32
C_USER_DWIDTH, 32, bits per channel, 1..32; zero-extended to 32 on read

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst  in  1  asynchronous, active-high reset
OPB_ABus  in  [0:31]  byte address
OPB_BE  in  [0:3]  byte enables; BE[3] selects bits [24:31]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero when not acking
Sl_xferAck  out  1  one-cycle transfer acknowledge
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
user_data_in  in  C_NUM_REGS*C_USER_DWIDTH  channel i occupies bits [i*W+W-1 : i*W]
snap_req  in  1  hardware snapshot strobe, one cycle per request
snap_done  out  1  one-cycle pulse, the cycle after a snapshot is captured

Behaviour:
- Word offset = OPB_ABus - C_BASEADDR; bits [30:31] ignored. Bit 31 is the LSB.
- Register map:
  - 0x00 CTRL, RW: bit31 MODE (0 = live, 1 = snapshot); bit30 SNAP, write-1 triggers a snapshot, self-clearing, reads 0.
  - 0x04 STATUS, RO: bits[16:31] = SNAP_CNT.
  - 0x08, 0x0C: reserved; read 0.
  - 0x10+4*i: CHAN[i].
- Hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Reads of in-range unmapped offsets return 0 and are acked. Writes to RO or unmapped offsets are acked and ignored.
- FSM, states IDLE and ACK:
  - IDLE: hit sampled at edge n -> ACK. Sl_xferAck=1 and Sl_DBus valid in cycle n+1 (latency 1).
  - ACK -> IDLE unconditionally.
  - A hit present in the ACK cycle is not sampled. A hit still present the following IDLE cycle starts a new transfer, so back-to-back acks occur at most every 2 cycles.
- Sl_DBus is registered and is 0 in every cycle with Sl_xferAck=0 (OR-bus safe).
- CTRL write takes effect at the ack edge, and only if OPB_BE[3]=1; otherwise the write is ignored but still acked.
- CHAN[i] read value:
  - MODE=0: live user_data_in channel i, sampled at the FSM IDLE->ACK edge.
  - MODE=1: snapshot register i.
- Snapshot trigger = snap_req OR (acked CTRL write with SNAP=1 and BE[3]=1).
- On a trigger, all C_NUM_REGS snapshot registers load user_data_in on the same edge and SNAP_CNT increments by 1, wrapping 0xFFFF->0x0000. snap_done pulses the following cycle.
- A snapshot is captured regardless of MODE.
- Simultaneous hardware and software triggers in the same cycle produce one snapshot and +1 count.
- A read of CHAN[i] sampled on the same edge as a snapshot returns the pre-snapshot value.
- Reset (asynchronous, any time including mid-transfer), all of the following go to 0 immediately; the FSM goes to IDLE and any in-flight transfer is dropped without ack:
  - all outputs
  - MODE
  - snapshot registers
  - SNAP_CNT
  - FSM state

Test Plan:
1. Reset, then read 0x01080104 -> Sl_xferAck exactly one cycle after select, Sl_DBus=0x00000000; errAck/retry/toutSup remain 0 throughout.
2. MODE=0, channel 2 = 0xDEADBEEF, read 0x01080118 -> 0xDEADBEEF one cycle after select. Same test with C_USER_DWIDTH=12 and channel value 0xABC -> 0x00000ABC.
3. Write CTRL=0x00000003 with BE=4'b1111, change all inputs, read CHAN[0..3] -> pre-change values; STATUS=1; snap_done pulsed once.
4. snap_req asserted in the same cycle as a SNAP write ack -> STATUS increments by exactly 1. Preload SNAP_CNT to 0xFFFF with 65535 prior snapshots, one more snapshot -> STATUS=0x0000.
5. Write CTRL with BE=4'b1110 -> acked, MODE unchanged. Read offset 0x0C and offset 0x10+4*C_NUM_REGS -> acked, data 0. Access at 0x01080200 -> no ack.
6. Hold select high for 6 cycles -> acks in cycles 1, 3, 5. Assert OPB_Rst during an ACK cycle -> Sl_xferAck and Sl_DBus drop to 0 immediately and MODE clears.

Source files
------------

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave exposing C_NUM_REGS user status words as read-only registers, with
// a CTRL/STATUS pair that selects live or snapshot reads and counts snapshots.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR    = 32'h01080100,
    parameter logic [31:0] C_HIGHADDR    = 32'h010801FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 4,
    parameter int          C_USER_DWIDTH = 32
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]               OPB_ABus,
    input  logic [0:3]                            OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]               OPB_DBus,
    input  logic                                  OPB_RNW,
    input  logic                                  OPB_select,
    input  logic                                  OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]               Sl_DBus,
    output logic                                  Sl_xferAck,
    output logic                                  Sl_errAck,
    output logic                                  Sl_retry,
    output logic                                  Sl_toutSup,
    input  logic [C_NUM_REGS*C_USER_DWIDTH-1:0]   user_data_in,
    input  logic                                  snap_req,
    output logic                                  snap_done
);

    localparam int UW = C_NUM_REGS * C_USER_DWIDTH;

    typedef enum logic {IDLE, ACK} state_t;

    state_t        state_q, state_d;
    logic          ack_q, ack_d;
    logic [31:0]   dbus_q, dbus_d;
    logic          wr_pend_q, wr_pend_d;
    logic          wr_mode_q, wr_mode_d;
    logic          wr_snap_q, wr_snap_d;
    logic          mode_q, mode_d;
    logic [UW-1:0] snap_q, snap_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          snap_done_q, snap_done_d;

    logic [31:0]   addr;
    logic [31:0]   offset;
    logic [29:0]   word;
    logic          hit;
    logic          ctrl_sel;
    logic [31:0]   rdata;
    logic          sw_trig;
    logic          trig;

    assign addr     = 32'(OPB_ABus);
    assign offset   = addr - C_BASEADDR;
    assign word     = offset[31:2];
    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign ctrl_sel = (word == 30'd0);

    // Read mux; channels zero-extend to the 32-bit bus
    always_comb begin
        rdata = '0;
        if (word == 30'd0) begin
            rdata[0] = mode_q;
        end else if (word == 30'd1) begin
            rdata = {16'b0, cnt_q};
        end
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word == 30'(i + 4)) begin
                rdata = mode_q ? 32'(snap_q[i*C_USER_DWIDTH +: C_USER_DWIDTH])
                               : 32'(user_data_in[i*C_USER_DWIDTH +: C_USER_DWIDTH]);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        dbus_d    = '0;
        wr_pend_d = 1'b0;
        wr_mode_d = 1'b0;
        wr_snap_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d   = ACK;
                    ack_d     = 1'b1;
                    dbus_d    = OPB_RNW ? rdata : 32'd0;
                    wr_pend_d = !OPB_RNW && ctrl_sel && OPB_BE[3];
                    wr_mode_d = OPB_DBus[C_OPB_DWIDTH-1];
                    wr_snap_d = OPB_DBus[C_OPB_DWIDTH-2];
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CTRL writes commit at the edge that closes the ack cycle
    assign sw_trig = (state_q == ACK) && wr_pend_q && wr_snap_q;
    assign trig    = snap_req || sw_trig;

    always_comb begin
        mode_d      = mode_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        snap_done_d = trig;
        if ((state_q == ACK) && wr_pend_q) begin
            mode_d = wr_mode_q;
        end
        if (trig) begin
            snap_d = user_data_in;
            cnt_d  = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            dbus_q      <= '0;
            wr_pend_q   <= 1'b0;
            wr_mode_q   <= 1'b0;
            wr_snap_q   <= 1'b0;
            mode_q      <= 1'b0;
            snap_q      <= '0;
            cnt_q       <= '0;
            snap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dbus_q      <= dbus_d;
            wr_pend_q   <= wr_pend_d;
            wr_mode_q   <= wr_mode_d;
            wr_snap_q   <= wr_snap_d;
            mode_q      <= mode_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            snap_done_q <= snap_done_d;
        end
    end

    assign Sl_DBus    = C_OPB_DWIDTH'(dbus_q);
    assign Sl_xferAck = ack_q;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign snap_done  = snap_done_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0], OPB_BE[0:2],
                         OPB_DBus[0:C_OPB_DWIDTH-3]};

endmodule
